// File: rtl/ddr2_pixel_arbiter.sv
// ddr2_pixel_arbiter: shares the DDR2 address/write-data/read-data FIFOs
// between the pixel feeder (reads) and the graphics writer (masked writes).
// Reads win by default. Define ARB_WRITE_FAIRNESS_EN to force a waiting
// write through after STARVE_MAX consecutive read grants.
module ddr2_pixel_arbiter #(
    parameter int unsigned STARVE_MAX = 32
) (
    input  logic         cpu_clk_g,
    input  logic         rst,
    // pixel feeder request port
    input  logic         pf_af_wr_en,
    input  logic [30:0]  pf_af_addr_din,
    output logic         pf_af_full,
    // pixel feeder read-data return
    output logic         pf_rdf_valid,
    output logic [127:0] pf_rdf_dout,
    input  logic         pf_rdf_rd_en,
    // graphics writer
    input  logic         gw_req,
    input  logic [30:0]  gw_addr,
    input  logic [255:0] gw_data,
    input  logic [31:0]  gw_mask,
    output logic         gw_ack,
    // DDR2 address FIFO
    output logic [2:0]   af_cmd_din,
    output logic [30:0]  af_addr_din,
    output logic         af_wr_en,
    input  logic         af_full,
    // DDR2 write-data FIFO
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din,
    output logic         wdf_wr_en,
    input  logic         wdf_full,
    // DDR2 read-data FIFO
    input  logic         rdf_valid,
    input  logic [127:0] rdf_dout,
    output logic         rdf_rd_en
);

    typedef enum logic {IDLE, WBEAT1} state_t;

    state_t state_q, state_d;
    logic   force_wr;
    logic   rd_sel;
    logic   wr_sel;

    // Grant decisions in IDLE; a read blocks the write in the same cycle.
    assign rd_sel = (state_q == IDLE) && pf_af_wr_en && !af_full && !force_wr;
    assign wr_sel = (state_q == IDLE) && gw_req && !rd_sel && !af_full && !wdf_full;

`ifdef ARB_WRITE_FAIRNESS_EN
    logic [5:0] starve_q, starve_d;

    assign force_wr = gw_req && ({26'd0, starve_q} >= STARVE_MAX);

    // Count read grants that overtake a waiting write; saturate at 63.
    always_comb begin
        starve_d = starve_q;
        if (!gw_req || wr_sel)
            starve_d = 6'd0;
        else if (rd_sel && (starve_q != 6'h3F))
            starve_d = starve_q + 6'd1;
    end

    // Starvation counter register.
    always_ff @(posedge cpu_clk_g) begin
        if (rst) starve_q <= 6'd0;
        else     starve_q <= starve_d;
    end
`else
    // Strict read priority: the threshold has no effect in this build.
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
    assign force_wr = 1'b0;
`endif

    // State register.
    always_ff @(posedge cpu_clk_g) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and all command/data strobes; reset forces the quiet values.
    always_comb begin
        state_d      = state_q;
        pf_af_full   = 1'b1;
        gw_ack       = 1'b0;
        af_wr_en     = 1'b0;
        af_cmd_din   = 3'b000;
        af_addr_din  = 31'd0;
        wdf_wr_en    = 1'b0;
        wdf_din      = 128'd0;
        wdf_mask_din = 16'd0;
        if (rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_sel) begin
                        af_wr_en    = 1'b1;
                        af_cmd_din  = 3'b001;
                        af_addr_din = pf_af_addr_din;
                        pf_af_full  = 1'b0;
                    end else if (wr_sel) begin
                        af_wr_en     = 1'b1;
                        af_cmd_din   = 3'b000;
                        af_addr_din  = gw_addr;
                        wdf_wr_en    = 1'b1;
                        wdf_din      = gw_data[127:0];
                        wdf_mask_din = gw_mask[15:0];
                        state_d      = WBEAT1;
                    end
                end
                WBEAT1: begin
                    if (!wdf_full) begin
                        wdf_wr_en    = 1'b1;
                        wdf_din      = gw_data[255:128];
                        wdf_mask_din = gw_mask[31:16];
                        gw_ack       = 1'b1;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read data goes straight through; only the feeder ever reads.
    assign pf_rdf_valid = rdf_valid;
    assign pf_rdf_dout  = rdf_dout;
    assign rdf_rd_en    = pf_rdf_rd_en;

endmodule

// File: tb/tb_ddr2_pixel_arbiter.sv
// Bench for ddr2_pixel_arbiter: directed test-plan scenarios followed by
// randomized traffic, every cycle compared with a behavioural model.
module tb_ddr2_pixel_arbiter;
    localparam int SMAX = 4;

    logic         cpu_clk_g = 1'b0;
    logic         rst;
    logic         pf_af_wr_en;
    logic [30:0]  pf_af_addr_din;
    logic         pf_af_full;
    logic         pf_rdf_valid;
    logic [127:0] pf_rdf_dout;
    logic         pf_rdf_rd_en;
    logic         gw_req;
    logic [30:0]  gw_addr;
    logic [255:0] gw_data;
    logic [31:0]  gw_mask;
    logic         gw_ack;
    logic [2:0]   af_cmd_din;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic         af_full;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;
    logic         wdf_full;
    logic         rdf_valid;
    logic [127:0] rdf_dout;
    logic         rdf_rd_en;

    always #5 cpu_clk_g = ~cpu_clk_g;

    ddr2_pixel_arbiter #(.STARVE_MAX(SMAX)) dut (
        .cpu_clk_g(cpu_clk_g), .rst(rst),
        .pf_af_wr_en(pf_af_wr_en), .pf_af_addr_din(pf_af_addr_din), .pf_af_full(pf_af_full),
        .pf_rdf_valid(pf_rdf_valid), .pf_rdf_dout(pf_rdf_dout), .pf_rdf_rd_en(pf_rdf_rd_en),
        .gw_req(gw_req), .gw_addr(gw_addr), .gw_data(gw_data), .gw_mask(gw_mask), .gw_ack(gw_ack),
        .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .af_full(af_full),
        .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en), .wdf_full(wdf_full),
        .rdf_valid(rdf_valid), .rdf_dout(rdf_dout), .rdf_rd_en(rdf_rd_en)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model state: is a write waiting to send its upper half, and how many
    // reads have overtaken the current waiting write.
    bit m_b1     = 1'b0;
    int m_starve = 0;
    // Observed-event counters for the directed scenarios.
    int n_rd, n_wcmd, n_beat, n_ack, n_acc;
    bit o_rdacc, o_ack;

    task automatic clr();
        n_rd = 0; n_wcmd = 0; n_beat = 0; n_ack = 0; n_acc = 0;
    endtask

    // One cycle: inputs were set just after the falling edge; check outputs,
    // advance the model as the rising edge would, wait for the next falling edge.
    task automatic tick();
        logic         e_af, e_wdf, e_ack, e_full;
        logic [2:0]   e_cmd;
        logic [30:0]  e_addr;
        logic [127:0] e_din;
        logic [15:0]  e_mask;
        bit           frc, rd, wg;
        #1;
        e_af = 0; e_wdf = 0; e_ack = 0; e_full = 1;
        e_cmd = 0; e_addr = 0; e_din = 0; e_mask = 0;
        frc = 0; rd = 0; wg = 0;
`ifdef ARB_WRITE_FAIRNESS_EN
        frc = gw_req && (m_starve >= SMAX);
`endif
        if (!rst) begin
            if (m_b1) begin
                if (!wdf_full) begin
                    e_wdf = 1; e_din = gw_data[255:128]; e_mask = gw_mask[31:16]; e_ack = 1;
                end
            end else if (pf_af_wr_en && !af_full && !frc) begin
                rd = 1; e_af = 1; e_cmd = 3'b001; e_addr = pf_af_addr_din; e_full = 0;
            end else if (gw_req && !af_full && !wdf_full) begin
                wg = 1; e_af = 1; e_cmd = 3'b000; e_addr = gw_addr;
                e_wdf = 1; e_din = gw_data[127:0]; e_mask = gw_mask[15:0];
            end
        end
        chk("af_wr_en", af_wr_en, e_af);
        chk("af_cmd", af_cmd_din, e_cmd);
        chk("af_addr", af_addr_din, e_addr);
        chk("wdf_wr_en", wdf_wr_en, e_wdf);
        chk("wdf_din", wdf_din, e_din);
        chk("wdf_mask", wdf_mask_din, e_mask);
        chk("gw_ack", gw_ack, e_ack);
        chk("pf_af_full", pf_af_full, e_full);
        chk("pt_valid", pf_rdf_valid, rdf_valid);
        chk("pt_dout", pf_rdf_dout, rdf_dout);
        chk("pt_rd_en", rdf_rd_en, pf_rdf_rd_en);
        o_rdacc = !pf_af_full;
        o_ack   = gw_ack;
        n_rd   += int'(af_wr_en && af_cmd_din == 3'b001);
        n_wcmd += int'(af_wr_en && af_cmd_din == 3'b000);
        n_beat += int'(wdf_wr_en);
        n_ack  += int'(gw_ack);
        n_acc  += int'(!pf_af_full);
        if (rst)       m_b1 = 0;
        else if (m_b1) m_b1 = wdf_full;
        else if (wg)   m_b1 = 1;
        if (rst || !gw_req || wg) m_starve = 0;
        else if (rd && m_starve < 63) m_starve++;
        @(negedge cpu_clk_g);
    endtask

    initial begin
        rst = 1; pf_af_wr_en = 0; pf_af_addr_din = 0; pf_rdf_rd_en = 0;
        gw_req = 0; gw_addr = 0; gw_data = 0; gw_mask = 0;
        af_full = 0; wdf_full = 0; rdf_valid = 0; rdf_dout = 0;
        o_rdacc = 0; o_ack = 0; clr();
        @(negedge cpu_clk_g);
        pf_af_wr_en = 1; gw_req = 1;     // requests under reset must be ignored
        tick(); tick();
        rst = 0; pf_af_wr_en = 0; gw_req = 0;
        tick();

        // Reads only: 10 back-to-back accepts.
        clr();
        for (int i = 0; i < 10; i++) begin
            pf_af_wr_en = 1; pf_af_addr_din = 31'(8 * i);
            tick();
        end
        pf_af_wr_en = 0;
        chk("reads_cnt", 32'(n_rd), 32'd10);
        chk("reads_acc", 32'(n_acc), 32'd10);

        // Single write, two cycles.
        clr();
        gw_req = 1; gw_addr = 31'h100; gw_data = {128'hB, 128'hA}; gw_mask = 0;
        tick();
        chk("w_cmd0", 32'(n_wcmd), 32'd1);
        chk("w_beat0", 32'(n_beat), 32'd1);
        tick();
        chk("w_beat1", 32'(n_beat), 32'd2);
        chk("w_ack", 32'(n_ack), 32'd1);
        gw_req = 0; tick();

        // Write-data FIFO full for 3 cycles in the second beat.
        clr();
        gw_req = 1; gw_addr = 31'h200; gw_data = {128'h22, 128'h11}; gw_mask = 32'hF00F_0FF0;
        tick();
        wdf_full = 1;
        repeat (3) tick();
        chk("stall_beats", 32'(n_beat), 32'd1);
        chk("stall_noack", 32'(n_ack), 32'd0);
        wdf_full = 0;
        tick();
        chk("stall_beat1", 32'(n_beat), 32'd2);
        chk("stall_ack", 32'(n_ack), 32'd1);
        gw_req = 0; tick();

        // Both requesting continuously for 24 cycles.
        clr();
        gw_req = 1; gw_addr = 31'h300; gw_data = {128'h44, 128'h33}; gw_mask = 0;
        for (int i = 0; i < 24; i++) begin
            pf_af_wr_en = 1; pf_af_addr_din = 31'(16 * i);
            tick();
        end
`ifdef ARB_WRITE_FAIRNESS_EN
        chk("fair_acks", 32'(n_ack), 32'd4);
        chk("fair_reads", 32'(n_rd), 32'd16);
`else
        chk("strict_acks", 32'(n_ack), 32'd0);
        chk("strict_reads", 32'(n_rd), 32'd24);
`endif
        pf_af_wr_en = 0; gw_req = 0; tick(); tick();

        // Reset during the second beat drops it; the held request reissues.
        clr();
        gw_req = 1; gw_addr = 31'h400; gw_data = {128'h66, 128'h55}; gw_mask = 32'h1;
        tick();
        rst = 1; tick();
        chk("rst_noack", 32'(n_ack), 32'd0);
        chk("rst_nobeat1", 32'(n_beat), 32'd1);
        rst = 0; tick();
        chk("rst_reissue", 32'(n_wcmd), 32'd2);
        tick();
        chk("rst_ack", 32'(n_ack), 32'd1);
        gw_req = 0; tick();

        // Read-data pass-through.
        rdf_valid = 1; rdf_dout = 128'hDEADBEEF; pf_rdf_rd_en = 1;
        #1;
        chk("pt_dead", pf_rdf_dout, 256'hDEADBEEF);
        chk("pt_v1", pf_rdf_valid, 1'b1);
        chk("pt_re1", rdf_rd_en, 1'b1);
        tick();
        rdf_valid = 0; pf_rdf_rd_en = 0;

        // Randomized traffic honouring the hold-until-accepted protocols.
        for (int i = 0; i < 3000; i++) begin
            if (!pf_af_wr_en || o_rdacc) begin
                pf_af_wr_en    = $urandom_range(0, 1) == 0;
                pf_af_addr_din = 31'($urandom);
            end
            if (!gw_req || o_ack) begin
                gw_req  = $urandom_range(0, 2) == 0;
                gw_addr = 31'($urandom);
                gw_data = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
                gw_mask = $urandom;
            end
            af_full      = $urandom_range(0, 7) == 0;
            wdf_full     = $urandom_range(0, 5) == 0;
            rst          = $urandom_range(0, 63) == 0;
            rdf_valid    = 1'($urandom);
            rdf_dout     = {$urandom, $urandom, $urandom, $urandom};
            pf_rdf_rd_en = 1'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
